// File: rtl/logic_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : logic_unit_pkg
//  Description : Opcode encodings and the bitwise operation shared by the
//                logic unit pipeline and anything that needs to model it.
//  Revision    : 1.0 - initial release
// ============================================================================
package logic_unit_pkg;

    // Widest operand the shared operation function handles; narrower callers
    // zero-extend on the way in and keep the low bits on the way out, which is
    // exact because every operation is purely bitwise.
    localparam int c_MAX_WIDTH = 64;

    typedef logic [c_MAX_WIDTH-1:0] lu_word_t;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NOT  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_XNOR = 3'd6;
    localparam logic [2:0] OP_LOAD = 3'd7;

    // Bitwise operation selected by op; B is ignored for NOT, A for LOAD.
    function automatic lu_word_t lu_op(input logic [2:0] op,
                                       input lu_word_t   a,
                                       input lu_word_t   b);
        lu_word_t y;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NOT:  y = ~a;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            default: y = b;
        endcase
        return y;
    endfunction

endpackage : logic_unit_pkg
`default_nettype wire

// File: rtl/pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage
//  Description : Width-generic register slice with valid/ready handshakes.
//                Holds one item; accepts a new one whenever it is empty or
//                its current item is being taken downstream in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              w_advance;

    assign w_advance = !r_valid || out_ready;
    assign in_ready  = w_advance;
    assign out_valid = r_valid;
    assign out_data  = r_data;

    // Load on advance; data only changes when a real item arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_advance) begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_data <= in_data;
            end
        end
    end

endmodule : pipe_stage
`default_nettype wire

// File: rtl/logic_unit_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : logic_unit_pipe
//  Description : Two-stage pipelined bitwise logic unit with an accumulator
//                operand option and registered zero/ones/parity flags.
//                WIDTH must lie in 1..64.
//  Revision    : 1.0 - initial release
// ============================================================================
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             out_ones,
    output logic             out_par,
    output logic [WIDTH-1:0] acc_q
);

    localparam int c_S2_W = WIDTH + 3;

    logic [WIDTH-1:0]  r_acc;
    logic [WIDTH-1:0]  w_a;
    lu_word_t          w_full;
    logic [WIDTH-1:0]  w_result;
    logic              w_accept;

    logic              w_s1_valid;
    logic [WIDTH-1:0]  w_s1_y;
    logic              w_s2_in_ready;
    logic [c_S2_W-1:0] w_s2_in_data;
    logic [c_S2_W-1:0] w_s2_data;

    assign w_a      = in_acc ? r_acc : in_a;
    assign w_full   = lu_op(in_op, lu_word_t'(w_a), lu_word_t'(in_b));
    assign w_result = w_full[WIDTH-1:0];
    assign w_accept = in_valid && in_ready;
    assign acc_q    = r_acc;

    // Accumulator tracks the result of every accepted transaction, so a
    // following accumulate op sees it on the very next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= ACC_INIT;
        end else if (w_accept) begin
            r_acc <= w_result;
        end
    end

    pipe_stage #(
        .DATA_W (WIDTH)
    ) u_stage1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_result),
        .out_valid (w_s1_valid),
        .out_ready (w_s2_in_ready),
        .out_data  (w_s1_y)
    );

    // Flags are derived from the stage-1 value and registered alongside it.
    assign w_s2_in_data = {^w_s1_y, &w_s1_y, ~|w_s1_y, w_s1_y};

    pipe_stage #(
        .DATA_W (c_S2_W)
    ) u_stage2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (w_s1_valid),
        .in_ready  (w_s2_in_ready),
        .in_data   (w_s2_in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_s2_data)
    );

    assign out_y    = w_s2_data[WIDTH-1:0];
    assign out_zero = w_s2_data[WIDTH];
    assign out_ones = w_s2_data[WIDTH+1];
    assign out_par  = w_s2_data[WIDTH+2];

endmodule : logic_unit_pipe
`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_logic_unit_pipe
//  Description : Directed self-checking bench for logic_unit_pipe (WIDTH=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_unit_pipe;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [2:0]   in_op;
    logic         in_acc;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_y;
    logic         out_zero;
    logic         out_ones;
    logic         out_par;
    logic [W-1:0] acc_q;

    int checks;
    int failures;

    logic_unit_pipe #(
        .WIDTH    (W),
        .ACC_INIT (8'h00)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_acc    (in_acc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_zero  (out_zero),
        .out_ones  (out_ones),
        .out_par   (out_par),
        .acc_q     (acc_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic set_in(input logic v, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic acc);
        in_valid = v;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_acc   = acc;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        out_ready = 1'b1;
        set_in(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (acc_q !== 8'h00) begin failures++; $display("FAIL reset_acc got=%h exp=00", acc_q); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_y !== 8'h00) begin failures++; $display("FAIL reset_out_y got=%h exp=00", out_y); end
        checks++; if ({out_zero, out_ones, out_par} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {out_zero, out_ones, out_par}); end
    endtask

    task automatic test_basic();
        set_in(1'b1, 3'd0, 8'hF0, 8'h3C, 1'b0);
        @(negedge clk);
        set_in(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_latency1 got=%b exp=0", out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
        checks++; if (out_y !== 8'h30) begin failures++; $display("FAIL basic_y got=%h exp=30", out_y); end
        checks++; if (out_zero !== 1'b0 || out_par !== 1'b0) begin failures++; $display("FAIL basic_flags got zero=%b par=%b exp zero=0 par=0", out_zero, out_par); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_sweep();
        logic [W-1:0] exp_y [8];
        exp_y = '{8'h05, 8'hAF, 8'h5A, 8'hFA, 8'h50, 8'hAA, 8'h55, 8'h0F};
        set_in(1'b1, 3'd0, 8'hA5, 8'h0F, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || out_y !== exp_y[k-2]) begin
                    failures++;
                    $display("FAIL sweep_op%0d got valid=%b y=%h exp valid=1 y=%h", k-2, out_valid, out_y, exp_y[k-2]);
                end
            end
            if (k < 8) begin
                checks++;
                if (in_ready !== 1'b1) begin failures++; $display("FAIL sweep_ready%0d got=%b exp=1", k, in_ready); end
                set_in(1'b1, 3'(k), 8'hA5, 8'h0F, 1'b0);
            end else begin
                set_in(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
            end
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL sweep_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_acc_chain();
        logic [W-1:0] exp_acc [3];
        exp_acc = '{8'h81, 8'h7E, 8'hFF};
        set_in(1'b1, 3'd7, 8'h33, 8'h81, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k <= 3) begin
                checks++;
                if (acc_q !== exp_acc[k-1]) begin failures++; $display("FAIL acc_step%0d got=%h exp=%h", k, acc_q, exp_acc[k-1]); end
            end
            if (k >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || out_y !== exp_acc[k-2]) begin
                    failures++;
                    $display("FAIL acc_out%0d got valid=%b y=%h exp valid=1 y=%h", k-2, out_valid, out_y, exp_acc[k-2]);
                end
            end
            if (k == 4) begin
                checks++;
                if (out_ones !== 1'b1) begin failures++; $display("FAIL acc_ones got=%b exp=1", out_ones); end
            end
            if (k == 1)      set_in(1'b1, 3'd5, 8'h33, 8'hFF, 1'b1);
            else if (k == 2) set_in(1'b1, 3'd1, 8'h33, 8'h81, 1'b1);
            else             set_in(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        set_in(1'b1, 3'd7, 8'h00, 8'h11, 1'b0);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready1 got=%b exp=1", in_ready); end
        @(negedge clk);
        set_in(1'b1, 3'd7, 8'h00, 8'h22, 1'b0);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready2 got=%b exp=1", in_ready); end
        @(negedge clk);
        set_in(1'b1, 3'd7, 8'h00, 8'h33, 1'b0);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready3 got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b1 || out_y !== 8'h11) begin failures++; $display("FAIL bp_head got valid=%b y=%h exp valid=1 y=11", out_valid, out_y); end
        repeat (2) @(negedge clk);
        checks++; if (out_y !== 8'h11 || out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold got valid=%b y=%h exp valid=1 y=11", out_valid, out_y); end
        checks++; if (acc_q !== 8'h22) begin failures++; $display("FAIL bp_acc_stall got=%h exp=22", acc_q); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_still_full got=%b exp=0", in_ready); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        set_in(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        checks++; if (out_valid !== 1'b1 || out_y !== 8'h22) begin failures++; $display("FAIL bp_second got valid=%b y=%h exp valid=1 y=22", out_valid, out_y); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_y !== 8'h33) begin failures++; $display("FAIL bp_third got valid=%b y=%h exp valid=1 y=33", out_valid, out_y); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_no_dup got=%b exp=0", out_valid); end
    endtask

    task automatic test_zero_parity();
        set_in(1'b1, 3'd0, 8'h55, 8'hAA, 1'b0);
        @(negedge clk);
        set_in(1'b1, 3'd7, 8'h00, 8'h07, 1'b0);
        @(negedge clk);
        set_in(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        checks++;
        if (out_y !== 8'h00 || out_zero !== 1'b1 || out_par !== 1'b0 || out_ones !== 1'b0) begin
            failures++;
            $display("FAIL zero_flags got y=%h z=%b o=%b p=%b exp y=00 z=1 o=0 p=0", out_y, out_zero, out_ones, out_par);
        end
        @(negedge clk);
        checks++;
        if (out_y !== 8'h07 || out_par !== 1'b1 || out_zero !== 1'b0) begin
            failures++;
            $display("FAIL parity_flags got y=%h z=%b p=%b exp y=07 z=0 p=1", out_y, out_zero, out_par);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        set_in(1'b1, 3'd7, 8'h00, 8'h3C, 1'b0);
        @(negedge clk);
        set_in(1'b1, 3'd7, 8'h00, 8'hC3, 1'b0);
        @(negedge clk);
        set_in(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL mid_full got valid=%b ready=%b exp valid=1 ready=0", out_valid, in_ready); end
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_async_valid got=%b exp=0", out_valid); end
        checks++; if (acc_q !== 8'h00) begin failures++; $display("FAIL mid_async_acc got=%h exp=00", acc_q); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_stale%0d got=%b exp=0", k, out_valid); end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_sweep();
        test_acc_chain();
        test_backpressure();
        test_zero_parity();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_logic_unit_pipe
`default_nettype wire
